// File: rtl/pcm_mem_arbiter.sv
// Two-port arbiter for the shared 2K x 16 PCM RAM: host and CPU0 req/ack ports,
// round-robin on ties, bounded host lock for read-modify-write, 4-cycle accesses.
module pcm_mem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic [DATA_W/8-1:0] host_be,
  input  logic                host_lock,
  output logic                host_ack,
  output logic [DATA_W-1:0]   host_rdata,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_ub_n,
  input  logic                cpu_lb_n,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [1:0]          owner
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);
  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_HOST = 2'b01;
  localparam logic [1:0] OWN_CPU  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic             last_host_r;
  logic [CNT_W-1:0] lock_cnt_r;
  logic             we_r;

  logic             grant_host_s;
  logic             grant_cpu_s;
  logic             lock_hold_s;
  logic [BE_W-1:0]  cpu_be_s;

  // Grant selection: the host lock overrides, otherwise alternate on ties.
  always_comb begin
    grant_host_s = 1'b0;
    grant_cpu_s  = 1'b0;
    cpu_be_s     = BE_W'({~cpu_ub_n, ~cpu_lb_n});
    lock_hold_s  = last_host_r && host_lock && host_req && (lock_cnt_r < LOCK_LIMIT);
    if (lock_hold_s) begin
      grant_host_s = 1'b1;
    end else if (host_req && cpu_req) begin
      if (last_host_r) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_host_s = 1'b1;
      end
    end else if (host_req) begin
      grant_host_s = 1'b1;
    end else if (cpu_req) begin
      grant_cpu_s = 1'b1;
    end else begin
      grant_host_s = 1'b0;
      grant_cpu_s  = 1'b0;
    end
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT -> DONE, all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      last_host_r <= 1'b0;
      lock_cnt_r  <= '0;
      we_r        <= 1'b0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_be      <= '0;
      owner       <= OWN_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          host_ack <= 1'b0;
          cpu_ack  <= 1'b0;
          if (grant_host_s) begin
            we_r        <= host_we;
            ram_en      <= 1'b1;
            ram_we      <= host_we;
            ram_addr    <= host_addr;
            ram_wdata   <= host_wdata;
            ram_be      <= host_be;
            owner       <= OWN_HOST;
            last_host_r <= 1'b1;
            // Only locked host grants that keep the CPU waiting use up the budget.
            if (!host_lock) begin
              lock_cnt_r <= '0;
            end else if (cpu_req) begin
              lock_cnt_r <= lock_cnt_r + CNT_W'(1);
            end
            state_r <= ST_ISSUE;
          end else if (grant_cpu_s) begin
            we_r        <= cpu_we;
            ram_en      <= 1'b1;
            ram_we      <= cpu_we;
            ram_addr    <= cpu_addr;
            ram_wdata   <= cpu_wdata;
            ram_be      <= cpu_be_s;
            owner       <= OWN_CPU;
            last_host_r <= 1'b0;
            lock_cnt_r  <= '0;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          ram_en    <= 1'b0;
          ram_we    <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= '0;
          ram_be    <= '0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!we_r) begin
            if (owner == OWN_HOST) begin
              host_rdata <= ram_rdata;
            end else begin
              cpu_rdata <= ram_rdata;
            end
          end
          host_ack <= (owner == OWN_HOST);
          cpu_ack  <= (owner == OWN_CPU);
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          host_ack <= 1'b0;
          cpu_ack  <= 1'b0;
          owner    <= OWN_IDLE;
          state_r  <= ST_IDLE;
        end
        default: begin
          host_ack <= 1'b0;
          cpu_ack  <= 1'b0;
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          owner    <= OWN_IDLE;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pcm_mem_arbiter.md
Name: pcm_mem_arbiter

Overview:
Arbitrates the single-port 2K x 16 PCM shared memory between two requesters: the Nios-side host port and the CPU0 coprocessor port. Each requester uses a req/ack handshake. The arbiter serialises accesses, drives the RAM port with registered signals, and returns read data with a one-cycle ack pulse. Round-robin fairness applies, plus a bounded host lock for atomic read-modify-write sequences.

Parameters:
ADDR_W, 11, word address width of shared RAM (depth 2**ADDR_W)
DATA_W, 16, data width; byte enables are DATA_W/8 = 2 bits
LOCK_MAX, 8, maximum consecutive host accesses under host_lock while cpu_req is pending

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
host_req  in  1  host access request; held with fields stable until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_be  in  2  host byte enables, active-high, [1] = upper byte
host_lock  in  1  keep grant with host across consecutive accesses
host_ack  out  1  one-cycle completion pulse to host
host_rdata  out  DATA_W  host read data, valid when host_ack = 1
cpu_req  in  1  CPU access request; same rules as host_req
cpu_we  in  1  1 = write
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ub_n  in  1  upper-byte enable, active-low
cpu_lb_n  in  1  lower-byte enable, active-low
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ack = 1
ram_en  out  1  RAM clock-enable / chipselect
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_be  out  2  RAM byte enables
ram_rdata  in  DATA_W  RAM read data; valid 1 cycle after ram_en read
owner  out  2  00 idle, 01 host, 10 CPU (current transaction owner)

Behaviour:
- All outputs are registered. On reset, every output goes to 0 immediately (asynchronously), state = IDLE, last_grant = CPU (so the host wins the first tie), and lock_cnt = 0.
- FSM has four states: IDLE, ISSUE, WAIT, DONE. Every access takes exactly 4 cycles.
- IDLE: evaluate eligible requests.
  - Only one requester asserting req: grant it.
  - Both asserting req: grant the requester that is not last_grant.
  - Lock override: if last_grant = host, host_lock = 1, host_req = 1 and lock_cnt < LOCK_MAX, grant the host regardless of cpu_req.
  - On a grant: latch we/addr/wdata/be; set owner and last_grant; go to ISSUE.
- CPU byte enables map as be = {~cpu_ub_n, ~cpu_lb_n}.
- ISSUE: ram_en = 1, ram_we = latched we, and ram_addr/ram_wdata/ram_be = latched fields, all for exactly this cycle. Go to WAIT.
- WAIT: ram_en = 0, ram_we = 0. If the access is a read, capture ram_rdata into the owner's rdata register. Go to DONE.
- DONE: the owner's ack = 1 for exactly this cycle. Clear owner to 00 on the exit edge. Go to IDLE.
- Ack latency: 3 cycles from the IDLE edge that samples req to the edge where ack rises.
- Requester may drop req in the cycle after ack, or keep it high with new fields; req high in IDLE after DONE counts as a new request.
- A write ack leaves that port's rdata unchanged. rdata holds its value until the next read completes on that port.
- be = 00 still performs the RAM cycle. Writes with be = 00 change no bytes. Reads always return the full word; be is ignored on reads.
- lock_cnt counts host accesses granted consecutively while host_lock = 1 and cpu_req = 1.
  - It clears on any CPU grant or any host grant with host_lock = 0.
  - When it reaches LOCK_MAX, the next IDLE with cpu_req = 1 grants the CPU.
- A request arriving during ISSUE, WAIT or DONE waits; there is no abort and no queue beyond the held req.
- Reset mid-access: the access is abandoned, no ack is issued, and a write may or may not have reached the RAM. Requesters must re-issue after reset.

Test Plan:
- Host read only: preload RAM[0x010] = 0xBEEF, host_req read addr 0x010 -> ram_en pulses 1 cycle at req+1, host_ack at req+3, host_rdata = 0xBEEF, cpu_ack stays 0.
- CPU byte write: cpu write addr 0x7FF data 0x1234, cpu_ub_n = 0, cpu_lb_n = 1 -> ram_be = 10, ram_we for 1 cycle; a host read of 0x7FF from prior value 0x0000 returns 0x1200.
- Simultaneous requests from reset: both req at the same cycle -> host acked first (ack at +3), CPU acked at +7; repeat both -> strict alternation host, CPU, host, CPU.
- Host lock with LOCK_MAX = 8: host_lock = 1 with continuous host_req while cpu_req is held -> exactly 8 host acks, then cpu_ack, then host resumes.
- Write with be = 00 to 0x020 holding 0xA5A5 -> ack issued, subsequent read returns 0xA5A5, host_rdata unchanged across the write ack.
- Reset asserted in WAIT of a CPU read -> all outputs 0 asynchronously, no cpu_ack; after release, a host request is granted first.
